fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//  - Drives the next-PC input of the PC register and consumes its current PC value.
//  - Issues in-order instruction-memory reads at pc_value over a valid/ready request channel.
//  - Buffers returned words with their PC in a FIFO and presents them to decode via valid/ready.
//  - Handles redirects (branch/jump) by flushing the FIFO and discarding in-flight responses.
// PARAMETERS
//  RESET_PC         32'h00003000  next_pc value while reset is asserted; matches the PC register's reset value
//  QUEUE_DEPTH      4             instruction FIFO entries; power of 2, >=2
//  MAX_OUTSTANDING  2             max accepted-but-unanswered memory requests, >=1
// PORTS
//  clock            in   1   rising-edge clock
//  reset            in   1   asynchronous, active-high
//  pc_value         in   32  current PC from the PC register
//  next_pc          out  32  next PC, fed to the PC register's jump input
//  redirect_valid   in   1   redirect request from execute (single-cycle pulse or level)
//  redirect_target  in   32  redirect destination
//  imem_req_valid   out  1   memory read request valid
//  imem_req_ready   in   1   memory accepts request
//  imem_req_addr    out  32  read address (= pc_value)
//  imem_rsp_valid   in   1   read data valid; in order; cannot be backpressured
//  imem_rsp_data    in   32  read data
//  inst_valid       out  1   instruction available to decode
//  inst_ready       in   1   decode consumes instruction
//  inst_data        out  32  FIFO head instruction
//  inst_pc          out  32  PC of FIFO head
// BEHAVIOUR
//  - Reset (async): FIFO empty, outstanding=0, discard=0, state=RUN.
//    Outputs during reset: inst_valid=0, imem_req_valid=0, next_pc=RESET_PC.
//  - next_pc (combinational):
//      redirect_valid          -> {redirect_target[31:2],2'b00}
//      else request fire       -> pc_value+4 (mod 2^32; 32'hFFFFFFFC wraps to 0)
//      else                    -> pc_value (hold)
//  - Request fire = imem_req_valid & imem_req_ready. imem_req_addr = pc_value.
//  - imem_req_valid = state==RUN & !redirect_valid & outstanding<MAX_OUTSTANDING
//    & (count+outstanding)<QUEUE_DEPTH.
//    Credit rule: every response is guaranteed a FIFO slot.
//  - Addresses of accepted requests go into a MAX_OUTSTANDING-deep tag FIFO.
//    Each non-discarded response pushes {data, tag PC} into the instruction FIFO.
//  - Pop on inst_valid & inst_ready. inst_valid = count!=0. inst_data/inst_pc come from the FIFO head.
//  - Push and pop in the same cycle: both occur, count unchanged.
//    Request fire and response in the same cycle: outstanding unchanged.
//  - States:
//      RUN   -> DRAIN when redirect_valid and outstanding (after this cycle's response) >0
//      RUN   -> stays RUN when redirect_valid with nothing in flight
//      DRAIN -> RUN when discard reaches 0
//  - On redirect_valid, in any state:
//      FIFO and tag FIFO are flushed.
//      discard = outstanding minus any response arriving this cycle; that response is dropped.
//      A pop of the FIFO head in the same cycle is still honoured.
//  - DRAIN: each response decrements discard and is dropped; no requests issue.
//    A further redirect in DRAIN updates next_pc only and leaves discard unchanged.
//  - Reset mid-operation: all state cleared immediately. Late responses arriving after reset are
//    not the block's concern; the memory is reset by the same reset.
// CONFIGURATION
//  FETCH_PERF_EN defined: adds outputs perf_fetch_count[31:0] and perf_flush_count[31:0].
//    perf_fetch_count: +1 per instruction popped to decode.
//    perf_flush_count: +1 per cycle with redirect_valid.
//    Both reset to 0 and wrap at 2^32.
//  FETCH_PERF_EN undefined: these ports and counters do not exist.
// TESTING
//  1 Reset, hold, release; zero-latency memory, inst_ready=1.
//    -> next_pc=32'h3000 in reset; first fetched inst_pc=3000, then 3004, 3008.
//  2 Memory latency 3 cycles, inst_ready=0.
//    -> at most 2 requests outstanding; imem_req_valid drops once count+outstanding=4;
//       next_pc holds pc_value while stalled.
//  3 Redirect to 32'h4002 with 2 in flight.
//    -> next_pc=4000; FIFO empty next cycle; both late responses dropped;
//       first delivered inst_pc=4000.
//  4 Redirect in the same cycle as a response and a pop.
//    -> popped instruction delivered; arriving response dropped; discard=outstanding-1.
//  5 pc_value=32'hFFFFFFFC with request fire.
//    -> next_pc=0.
//  6 FETCH_PERF_EN: 5 pops and 2 redirect cycles.
//    -> perf_fetch_count=5, perf_flush_count=2; reset clears both to 0.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: drives the PC register's next value, issues in-order
// instruction-memory reads, buffers returned words with their PC and hands them to decode.
// Redirects flush all buffered state; responses still in flight are counted down and dropped.
// Optional build macro FETCH_PERF_EN adds perf_fetch_count / perf_flush_count outputs.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC        = 32'h0000_3000,
  parameter int unsigned QUEUE_DEPTH     = 4,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pc_value,
  output logic [31:0] next_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
`ifdef FETCH_PERF_EN
  output logic [31:0] perf_fetch_count,
  output logic [31:0] perf_flush_count,
`endif
  output logic [31:0] inst_pc
);

  localparam int unsigned QAW = $clog2(QUEUE_DEPTH);
  localparam int unsigned CW  = QAW + 1;
  localparam int unsigned TAW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned OW  = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic {StRun, StDrain} state_e;

  state_e           state_q;
  logic [QAW-1:0]   q_wr_q, q_rd_q;
  logic [CW-1:0]    q_count_q;
  logic [31:0]      q_data [QUEUE_DEPTH];
  logic [31:0]      q_pc   [QUEUE_DEPTH];
  logic [TAW-1:0]   tag_wr_q, tag_rd_q;
  logic [31:0]      tag_pc [MAX_OUTSTANDING];
  logic [OW-1:0]    outstanding_q, discard_q;

  logic          fire, pop, push, rsp_dec, credit_ok;
  logic [OW-1:0] outstanding_d, discard_d;

  function automatic logic [TAW-1:0] tag_inc(input logic [TAW-1:0] p);
    return (32'(p) == MAX_OUTSTANDING - 1) ? '0 : p + TAW'(1);
  endfunction

  // Request gating, handshakes and the in-flight / discard bookkeeping
  always_comb begin
    // Every accepted request must already own a FIFO slot for its response
    credit_ok      = (32'(q_count_q) + 32'(outstanding_q)) < QUEUE_DEPTH;
    imem_req_valid = ~reset & (state_q == StRun) & ~redirect_valid &
                     (32'(outstanding_q) < MAX_OUTSTANDING) & credit_ok;
    imem_req_addr  = pc_value;
    fire           = imem_req_valid & imem_req_ready;
    inst_valid     = (q_count_q != '0);
    inst_data      = q_data[q_rd_q];
    inst_pc        = q_pc[q_rd_q];
    pop            = inst_valid & inst_ready;
    rsp_dec        = imem_rsp_valid & (outstanding_q != '0);
    push           = rsp_dec & (state_q == StRun) & ~redirect_valid;
    outstanding_d  = outstanding_q + OW'(fire) - OW'(rsp_dec);
    discard_d      = discard_q;
    if (redirect_valid) begin
      // Everything still in flight after this cycle's response belongs to the old stream
      discard_d = outstanding_q - OW'(rsp_dec);
    end else if (rsp_dec && discard_q != '0) begin
      discard_d = discard_q - OW'(1);
    end
  end

  // Next PC for the PC register: redirect beats sequential advance beats hold
  always_comb begin
    if (reset) begin
      next_pc = RESET_PC;
    end else if (redirect_valid) begin
      next_pc = redirect_target & 32'hFFFF_FFFC;
    end else if (fire) begin
      next_pc = pc_value + 32'd4;
    end else begin
      next_pc = pc_value;
    end
  end

  // Control state: FSM, FIFO pointers/count, tag pointers and counters
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= StRun;
      q_wr_q        <= '0;
      q_rd_q        <= '0;
      q_count_q     <= '0;
      tag_wr_q      <= '0;
      tag_rd_q      <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      state_q       <= (discard_d != '0) ? StDrain : StRun;
      if (redirect_valid) begin
        q_wr_q    <= '0;
        q_rd_q    <= '0;
        q_count_q <= '0;
        tag_wr_q  <= '0;
        tag_rd_q  <= '0;
      end else begin
        if (push) q_wr_q <= q_wr_q + QAW'(1);
        if (pop)  q_rd_q <= q_rd_q + QAW'(1);
        q_count_q <= q_count_q + CW'(push) - CW'(pop);
        if (fire) tag_wr_q <= tag_inc(tag_wr_q);
        if (push) tag_rd_q <= tag_inc(tag_rd_q);
      end
    end
  end

  // Storage arrays: instruction FIFO and request-address tags
  always_ff @(posedge clock) begin
    if (push) begin
      q_data[q_wr_q] <= imem_rsp_data;
      q_pc[q_wr_q]   <= tag_pc[tag_rd_q];
    end
    if (fire) tag_pc[tag_wr_q] <= pc_value;
  end

`ifdef FETCH_PERF_EN
  // Performance counters: delivered instructions and redirect cycles
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_fetch_count <= '0;
      perf_flush_count <= '0;
    end else begin
      perf_fetch_count <= perf_fetch_count + 32'(pop);
      perf_flush_count <= perf_flush_count + 32'(redirect_valid);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: a PC register, an in-order memory with
// configurable latency and a queue-level reference model of the fetched stream.
module tb_fetch_sequencer;

  localparam logic [31:0] RPC   = 32'h0000_3000;
  localparam int          DEPTH = 4;
  localparam int          MAXO  = 2;

  logic        clock, reset;
  logic [31:0] pc_value, next_pc, redirect_target, imem_req_addr, imem_rsp_data;
  logic [31:0] inst_data, inst_pc;
  logic        redirect_valid, imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic        inst_valid, inst_ready;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_count, perf_flush_count;
`endif

  fetch_sequencer dut (
    .clock           (clock),
    .reset           (reset),
    .pc_value        (pc_value),
    .next_pc         (next_pc),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst_data       (inst_data),
`ifdef FETCH_PERF_EN
    .perf_fetch_count(perf_fetch_count),
    .perf_flush_count(perf_flush_count),
`endif
    .inst_pc         (inst_pc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  req_t        mem_q[$];
  logic [31:0] inst_q[$];   // PCs of buffered instructions, oldest first
  logic [31:0] pop_log[$];  // DUT inst_pc at every pop
  int          inflight, discard, cyc, last_due, lat_min, lat_max;
  int          total, bad, pops, flushes;
  logic [31:0] pc_reg, stream_pc;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // One clock cycle; called at posedge+1 with redirect/ready inputs already set
  task automatic cycle();
    logic        rsp, exp_rv, exp_iv, fire, pop;
    logic [31:0] exp_np;
    int          due;
    rsp = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? memword(mem_q[0].addr) : $urandom;
    #3;
    exp_rv = !redirect_valid && discard == 0 && inflight < MAXO &&
             (inst_q.size() + inflight) < DEPTH;
    fire   = exp_rv && imem_req_ready;
    exp_iv = inst_q.size() != 0;
    pop    = exp_iv && inst_ready;
    exp_np = redirect_valid ? (redirect_target & 32'hFFFF_FFFC) :
             fire ? pc_reg + 32'd4 : pc_reg;
    total++;
    if (next_pc !== exp_np) begin
      bad++; $display("FAIL next_pc cyc=%0d: got %h want %h", cyc, next_pc, exp_np);
    end
    total++;
    if (imem_req_valid !== exp_rv) begin
      bad++; $display("FAIL req_valid cyc=%0d: got %b want %b", cyc, imem_req_valid, exp_rv);
    end
    if (exp_rv) begin
      total++;
      if (imem_req_addr !== pc_reg) begin
        bad++; $display("FAIL req_addr cyc=%0d: got %h want %h", cyc, imem_req_addr, pc_reg);
      end
    end
    total++;
    if (inst_valid !== exp_iv) begin
      bad++; $display("FAIL inst_valid cyc=%0d: got %b want %b", cyc, inst_valid, exp_iv);
    end
    if (exp_iv) begin
      total++;
      if (inst_pc !== inst_q[0] || inst_data !== memword(inst_q[0])) begin
        bad++;
        $display("FAIL inst_head cyc=%0d: got pc %h data %h want pc %h data %h", cyc,
                 inst_pc, inst_data, inst_q[0], memword(inst_q[0]));
      end
    end
    if (pop) begin
      total++;
      if (inst_pc !== stream_pc) begin
        bad++; $display("FAIL stream_pc cyc=%0d: got %h want %h", cyc, inst_pc, stream_pc);
      end
      pop_log.push_back(inst_pc);
      void'(inst_q.pop_front());
      stream_pc += 32'd4;
      pops++;
    end
    if (rsp) begin
      if (!redirect_valid && discard == 0) inst_q.push_back(mem_q[0].addr);
      else if (discard > 0) discard--;
      void'(mem_q.pop_front());
      inflight--;
    end
    if (redirect_valid) begin
      inst_q.delete();
      discard   = inflight;
      stream_pc = redirect_target & 32'hFFFF_FFFC;
      flushes++;
    end
    if (fire) begin
      due = cyc + $urandom_range(lat_max, lat_min);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      mem_q.push_back('{addr: pc_reg, due: due});
      inflight++;
    end
    pc_reg = exp_np;
    @(posedge clock);
    #1;
    pc_value = pc_reg;
    cyc++;
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b0;
    pc_value       = RPC;
    #3;
    total++;
    if (next_pc !== RPC) begin
      bad++; $display("FAIL reset_next_pc: got %h want %h", next_pc, RPC);
    end
    total++;
    if (inst_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
      bad++; $display("FAIL reset_valids: got inst %b req %b want 0 0", inst_valid, imem_req_valid);
    end
    repeat (2) @(posedge clock);
    #1;
    inst_q.delete(); mem_q.delete(); pop_log.delete();
    inflight = 0; discard = 0; cyc = 0; last_due = -1; pops = 0; flushes = 0;
    pc_reg = RPC; stream_pc = RPC; pc_value = RPC;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    inst_ready = 1'b1; imem_req_ready = 1'b1; redirect_target = '0;
    do_reset();
  endtask

  task automatic test_basic();
    lat_min = 1; lat_max = 1; inst_ready = 1'b1; imem_req_ready = 1'b1;
    pop_log.delete();
    repeat (12) cycle();
    total++;
    if (pop_log.size() < 3 || pop_log[0] !== 32'h3000 || pop_log[1] !== 32'h3004 ||
        pop_log[2] !== 32'h3008) begin
      bad++; $display("FAIL basic_order: got %0d pops first %h want 3000,3004,3008",
                      pop_log.size(), (pop_log.size() > 0) ? pop_log[0] : 32'hx);
    end
  endtask

  task automatic test_latency();
    lat_min = 3; lat_max = 3; inst_ready = 1'b0; imem_req_ready = 1'b1;
    repeat (24) cycle();
    #1;
    total++;
    if (imem_req_valid !== 1'b0 || inst_valid !== 1'b1 || next_pc !== pc_value) begin
      bad++; $display("FAIL latency_stall: got req %b inst %b next_pc %h want 0 1 %h",
                      imem_req_valid, inst_valid, next_pc, pc_value);
    end
  endtask

  task automatic test_redirect();
    int n;
    lat_min = 3; lat_max = 3; inst_ready = 1'b1; imem_req_ready = 1'b1;
    n = 0;
    while (!(inflight == MAXO && !(mem_q.size() > 0 && mem_q[0].due <= cyc)) && n < 30) begin
      cycle(); n++;
    end
    total++;
    if (n >= 30) begin
      bad++; $display("FAIL redirect_setup: got timeout want 2 in flight");
    end
    redirect_valid = 1'b1; redirect_target = 32'h0000_4002;
    #1;
    total++;
    if (next_pc !== 32'h4000) begin
      bad++; $display("FAIL redirect_next_pc: got %h want 00004000", next_pc);
    end
    cycle();
    redirect_valid = 1'b0;
    total++;
    if (inst_valid !== 1'b0) begin
      bad++; $display("FAIL redirect_flush: got inst_valid %b want 0", inst_valid);
    end
    pop_log.delete();
    n = 0;
    while (pop_log.size() == 0 && n < 40) begin
      cycle(); n++;
    end
    total++;
    if (pop_log.size() == 0 || pop_log[0] !== 32'h4000) begin
      bad++; $display("FAIL redirect_first: got %0d pops first %h want 00004000", pop_log.size(),
                      (pop_log.size() > 0) ? pop_log[0] : 32'hx);
    end
  endtask

  task automatic test_same_cycle();
    int          n;
    logic [31:0] head;
    lat_min = 2; lat_max = 2; inst_ready = 1'b0; imem_req_ready = 1'b1;
    n = 0;
    while (!(inst_q.size() >= 1 && mem_q.size() > 0 && mem_q[0].due <= cyc) && n < 30) begin
      cycle(); n++;
    end
    total++;
    if (n >= 30) begin
      bad++; $display("FAIL same_setup: got timeout want response with buffered head");
    end
    head = (inst_q.size() > 0) ? inst_q[0] : 32'h0;
    pop_log.delete();
    inst_ready = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h0000_8001;
    cycle();
    redirect_valid = 1'b0;
    total++;
    if (pop_log.size() != 1 || pop_log[0] !== head || inst_valid !== 1'b0) begin
      bad++; $display("FAIL same_cycle_pop: got %0d pops pc %h valid %b want 1 pop pc %h valid 0",
                      pop_log.size(), (pop_log.size() > 0) ? pop_log[0] : 32'hx, inst_valid, head);
    end
    repeat (12) cycle();
  endtask

  task automatic test_wrap();
    int n;
    lat_min = 1; lat_max = 2; inst_ready = 1'b1; imem_req_ready = 1'b1;
    redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFE;
    cycle();
    redirect_valid = 1'b0;
    n = 0;
    #1;
    while (!imem_req_valid && n < 20) begin
      cycle(); #1; n++;
    end
    total++;
    if (pc_value !== 32'hFFFF_FFFC || imem_req_valid !== 1'b1 || next_pc !== 32'h0) begin
      bad++; $display("FAIL wrap: got pc %h req %b next_pc %h want fffffffc 1 00000000",
                      pc_value, imem_req_valid, next_pc);
    end
    repeat (10) cycle();
  endtask

  task automatic test_random();
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 500; i++) begin
      if (i == 250) do_reset();
      imem_req_ready  = ($urandom_range(3, 0) != 0);
      inst_ready      = ($urandom_range(2, 0) != 0);
      redirect_valid  = ($urandom_range(15, 0) == 0);
      redirect_target = $urandom;
      cycle();
    end
    redirect_valid = 1'b0;
  endtask

`ifdef FETCH_PERF_EN
  task automatic test_perf();
    int n;
    do_reset();
    lat_min = 1; lat_max = 1; imem_req_ready = 1'b1;
    n = 0;
    while (pops < 5 && n < 40) begin
      inst_ready = 1'b1; cycle(); n++;
    end
    inst_ready = 1'b0;
    redirect_target = 32'h0000_5000;
    redirect_valid = 1'b1; cycle(); cycle();
    redirect_valid = 1'b0; cycle();
    total++;
    if (perf_fetch_count !== 32'd5 || perf_flush_count !== 32'd2) begin
      bad++; $display("FAIL perf_counts: got %0d %0d want 5 2", perf_fetch_count, perf_flush_count);
    end
    reset = 1'b1;
    #2;
    total++;
    if (perf_fetch_count !== 32'd0 || perf_flush_count !== 32'd0) begin
      bad++; $display("FAIL perf_reset: got %0d %0d want 0 0", perf_fetch_count, perf_flush_count);
    end
    do_reset();
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    total = 0; bad = 0;
    reset = 1'b1; redirect_valid = 1'b0; redirect_target = '0; imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0; inst_ready = 1'b0; pc_value = RPC;
    lat_min = 1; lat_max = 1;
    @(posedge clock);
    #1;
    test_reset();
    test_basic();
    test_latency();
    test_redirect();
    test_same_cycle();
    test_wrap();
    test_random();
`ifdef FETCH_PERF_EN
    test_perf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
